// File: rtl/ex_stage.sv
// -----------------------------------------------------------------------------
// ex_stage : execute stage of a 5-stage RV32IM pipeline.
//
// Consumes the ID/EX register outputs and produces the write-back result and
// memory-access fields for the EX/MEM register. Base-ISA operations and the
// MUL family finish in one cycle. DIV/DIVU/REM/REMU run on a restoring
// divider (one quotient bit per cycle) and hold the pipeline via stallreq_ex.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   addr_pc_ex        PC of the instruction in EX
//   r1_ex, r2_ex      operands (r2_ex may carry an immediate)
//   wvalid_ex         instruction writes rd
//   waddr_ex          rd index
//   alusel_ex         operation class
//   aluop_ex          operation code
//   store_imm_ex      load/store address offset
//   stall             global stall vector (bit 4 = MEM held)
//   flush             annul the instruction in EX
//   wvalid_o/waddr_o/wdata_o   write-back fields toward EX/MEM
//   aluop_o           operation code passed to MEM
//   mem_addr_o        r1_ex + store_imm_ex
//   mem_wdata_o       store data (r2_ex)
//   stallreq_ex       divide in progress, hold the pipeline
// -----------------------------------------------------------------------------
module ex_stage #(
    parameter int DIV_STEPS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr_pc_ex,
    input  logic [31:0] r1_ex,
    input  logic [31:0] r2_ex,
    input  logic        wvalid_ex,
    input  logic [4:0]  waddr_ex,
    input  logic [2:0]  alusel_ex,
    input  logic [6:0]  aluop_ex,
    input  logic [31:0] store_imm_ex,
    input  logic [5:0]  stall,
    input  logic        flush,
    output logic        wvalid_o,
    output logic [4:0]  waddr_o,
    output logic [31:0] wdata_o,
    output logic [6:0]  aluop_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        stallreq_ex
);

    localparam int CNT_W = $clog2(DIV_STEPS);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIV_STEPS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Operation classes
    localparam logic [2:0] SEL_NOP    = 3'd0;
    localparam logic [2:0] SEL_LOGIC  = 3'd1;
    localparam logic [2:0] SEL_SHIFT  = 3'd2;
    localparam logic [2:0] SEL_ARITH  = 3'd3;
    localparam logic [2:0] SEL_MULDIV = 3'd4;
    localparam logic [2:0] SEL_LDST   = 3'd5;
    localparam logic [2:0] SEL_JUMP   = 3'd6;

    // Operation codes
    localparam logic [6:0] OP_AND    = 7'h01;
    localparam logic [6:0] OP_OR     = 7'h02;
    localparam logic [6:0] OP_XOR    = 7'h03;
    localparam logic [6:0] OP_SLL    = 7'h04;
    localparam logic [6:0] OP_SRL    = 7'h05;
    localparam logic [6:0] OP_SRA    = 7'h06;
    localparam logic [6:0] OP_ADD    = 7'h07;
    localparam logic [6:0] OP_SUB    = 7'h08;
    localparam logic [6:0] OP_SLT    = 7'h09;
    localparam logic [6:0] OP_SLTU   = 7'h0A;
    localparam logic [6:0] OP_LUI    = 7'h0B;
    localparam logic [6:0] OP_AUIPC  = 7'h0C;
    localparam logic [6:0] OP_MUL    = 7'h0D;
    localparam logic [6:0] OP_MULH   = 7'h0E;
    localparam logic [6:0] OP_MULHSU = 7'h0F;
    localparam logic [6:0] OP_MULHU  = 7'h10;
    localparam logic [6:0] OP_DIV    = 7'h11;
    localparam logic [6:0] OP_DIVU   = 7'h12;
    localparam logic [6:0] OP_REM    = 7'h13;
    localparam logic [6:0] OP_REMU   = 7'h14;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } div_state_e;

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      quot_q, quot_d;      // dividend shifts out, quotient shifts in
    logic [31:0]      rem_q, rem_d;
    logic [31:0]      divisor_q, divisor_d;
    logic             neg_quot_q, neg_quot_d;
    logic             neg_rem_q, neg_rem_d;
    logic             rem_sel_q, rem_sel_d;

    // Only stall[4] matters here; the other bits belong to other stages.
    logic unused_stall_s;
    assign unused_stall_s = ^{stall[5], stall[3:0]};

    // ---------------- divide request decode ----------------
    logic        div_op_s, div_signed_s, rem_op_s;
    logic        dividend_neg_s, divisor_neg_s;
    logic        div_by_zero_s, div_ovf_s;
    logic [31:0] dividend_abs_s, divisor_abs_s;

    assign div_op_s       = (alusel_ex == SEL_MULDIV) &&
                            ((aluop_ex == OP_DIV) || (aluop_ex == OP_DIVU) ||
                             (aluop_ex == OP_REM) || (aluop_ex == OP_REMU));
    assign div_signed_s   = (aluop_ex == OP_DIV) || (aluop_ex == OP_REM);
    assign rem_op_s       = (aluop_ex == OP_REM) || (aluop_ex == OP_REMU);
    assign dividend_neg_s = div_signed_s & r1_ex[31];
    assign divisor_neg_s  = div_signed_s & r2_ex[31];
    assign dividend_abs_s = dividend_neg_s ? (32'd0 - r1_ex) : r1_ex;
    assign divisor_abs_s  = divisor_neg_s  ? (32'd0 - r2_ex) : r2_ex;
    assign div_by_zero_s  = (r2_ex == 32'd0);
    assign div_ovf_s      = div_signed_s && (r1_ex == 32'h8000_0000) &&
                            (r2_ex == 32'hFFFF_FFFF);

    // ---------------- one restoring step ----------------
    // The partial remainder is always below the divisor, so the shifted value
    // fits in 33 bits and bit 32 of the difference is a clean borrow flag.
    logic [32:0] rem_shift_s, rem_diff_s;
    logic [31:0] step_quot_s, step_rem_s;

    assign rem_shift_s = {rem_q, quot_q[31]};
    assign rem_diff_s  = rem_shift_s - {1'b0, divisor_q};
    assign step_quot_s = {quot_q[30:0], ~rem_diff_s[32]};
    assign step_rem_s  = rem_diff_s[32] ? rem_shift_s[31:0] : rem_diff_s[31:0];

    // Divider next-state logic: start, iterate, sign-correct, hold result.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        divisor_d  = divisor_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        rem_sel_d  = rem_sel_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (div_op_s) begin
                        rem_sel_d = rem_op_s;
                        if (div_by_zero_s) begin
                            quot_d  = 32'hFFFF_FFFF;
                            rem_d   = r1_ex;
                            state_d = S_DONE;
                        end else if (div_ovf_s) begin
                            quot_d  = 32'h8000_0000;
                            rem_d   = 32'd0;
                            state_d = S_DONE;
                        end else begin
                            quot_d     = dividend_abs_s;
                            rem_d      = 32'd0;
                            divisor_d  = divisor_abs_s;
                            neg_quot_d = dividend_neg_s ^ divisor_neg_s;
                            neg_rem_d  = dividend_neg_s;
                            cnt_d      = '0;
                            state_d    = S_BUSY;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_BUSY: begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == LAST_STEP) begin
                        quot_d  = neg_quot_q ? (32'd0 - step_quot_s) : step_quot_s;
                        rem_d   = neg_rem_q  ? (32'd0 - step_rem_s)  : step_rem_s;
                        state_d = S_DONE;
                    end else begin
                        quot_d  = step_quot_s;
                        rem_d   = step_rem_s;
                        state_d = S_BUSY;
                    end
                end
                S_DONE: begin
                    // Hold the result while MEM is frozen, it has not been taken yet.
                    if (stall[4]) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Divider state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            quot_q     <= 32'd0;
            rem_q      <= 32'd0;
            divisor_q  <= 32'd0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            rem_sel_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            divisor_q  <= divisor_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            rem_sel_q  <= rem_sel_d;
        end
    end

    // ---------------- single-cycle datapath ----------------
    logic        mul_a_signed_s, mul_b_signed_s;
    logic [65:0] mul_a_s, mul_b_s, mul_prod_s;
    logic [32:0] slt_diff_s, sltu_diff_s;
    logic [31:0] sra_s, div_res_s, alu_res_s;

    // Sign-extending to the full product width makes the modular product equal
    // the 33x33 signed product of the extended operands.
    assign mul_a_signed_s = (aluop_ex == OP_MULH) || (aluop_ex == OP_MULHSU);
    assign mul_b_signed_s = (aluop_ex == OP_MULH);
    assign mul_a_s        = {{34{mul_a_signed_s & r1_ex[31]}}, r1_ex};
    assign mul_b_s        = {{34{mul_b_signed_s & r2_ex[31]}}, r2_ex};
    assign mul_prod_s     = mul_a_s * mul_b_s;

    assign slt_diff_s  = {r1_ex[31], r1_ex} - {r2_ex[31], r2_ex};
    assign sltu_diff_s = {1'b0, r1_ex} - {1'b0, r2_ex};
    assign sra_s       = $signed(r1_ex) >>> r2_ex[4:0];
    assign div_res_s   = (state_q == S_DONE) ? (rem_sel_q ? rem_q : quot_q) : 32'd0;

    // Result mux over operation class and code.
    always_comb begin
        alu_res_s = 32'd0;
        case (alusel_ex)
            SEL_LOGIC: begin
                case (aluop_ex)
                    OP_AND:  alu_res_s = r1_ex & r2_ex;
                    OP_OR:   alu_res_s = r1_ex | r2_ex;
                    OP_XOR:  alu_res_s = r1_ex ^ r2_ex;
                    default: alu_res_s = 32'd0;
                endcase
            end
            SEL_SHIFT: begin
                case (aluop_ex)
                    OP_SLL:  alu_res_s = r1_ex << r2_ex[4:0];
                    OP_SRL:  alu_res_s = r1_ex >> r2_ex[4:0];
                    OP_SRA:  alu_res_s = sra_s;
                    default: alu_res_s = 32'd0;
                endcase
            end
            SEL_ARITH: begin
                case (aluop_ex)
                    OP_ADD:   alu_res_s = r1_ex + r2_ex;
                    OP_SUB:   alu_res_s = r1_ex - r2_ex;
                    OP_SLT:   alu_res_s = {31'd0, slt_diff_s[32]};
                    OP_SLTU:  alu_res_s = {31'd0, sltu_diff_s[32]};
                    OP_LUI:   alu_res_s = r2_ex;
                    OP_AUIPC: alu_res_s = addr_pc_ex + r2_ex;
                    default:  alu_res_s = 32'd0;
                endcase
            end
            SEL_MULDIV: begin
                case (aluop_ex)
                    OP_MUL:                        alu_res_s = mul_prod_s[31:0];
                    OP_MULH, OP_MULHSU, OP_MULHU:  alu_res_s = mul_prod_s[63:32];
                    OP_DIV, OP_DIVU, OP_REM, OP_REMU: alu_res_s = div_res_s;
                    default:                       alu_res_s = 32'd0;
                endcase
            end
            SEL_LDST: alu_res_s = 32'd0;
            SEL_JUMP: alu_res_s = addr_pc_ex + 32'd4;
            default:  alu_res_s = 32'd0;
        endcase
    end

    // Reset is folded in so an aborted divide releases the pipeline at once.
    assign stallreq_ex = div_op_s && (state_q != S_DONE) && !flush && !rst;

    // Write enable: bubble on flush, nop, or while the divider holds EX.
    always_comb begin
        wvalid_o = 1'b0;
        if (flush || stallreq_ex || (alusel_ex == SEL_NOP)) begin
            wvalid_o = 1'b0;
        end else begin
            wvalid_o = wvalid_ex;
        end
    end

    assign wdata_o     = alu_res_s;
    assign waddr_o     = waddr_ex;
    assign aluop_o     = aluop_ex;
    assign mem_addr_o  = r1_ex + store_imm_ex;
    assign mem_wdata_o = r2_ex;

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;

    localparam logic [2:0] SEL_NOP    = 3'd0;
    localparam logic [2:0] SEL_LOGIC  = 3'd1;
    localparam logic [2:0] SEL_SHIFT  = 3'd2;
    localparam logic [2:0] SEL_ARITH  = 3'd3;
    localparam logic [2:0] SEL_MULDIV = 3'd4;
    localparam logic [2:0] SEL_LDST   = 3'd5;
    localparam logic [2:0] SEL_JUMP   = 3'd6;

    localparam logic [6:0] OP_AND    = 7'h01;
    localparam logic [6:0] OP_OR     = 7'h02;
    localparam logic [6:0] OP_XOR    = 7'h03;
    localparam logic [6:0] OP_SLL    = 7'h04;
    localparam logic [6:0] OP_SRL    = 7'h05;
    localparam logic [6:0] OP_SRA    = 7'h06;
    localparam logic [6:0] OP_ADD    = 7'h07;
    localparam logic [6:0] OP_SUB    = 7'h08;
    localparam logic [6:0] OP_SLT    = 7'h09;
    localparam logic [6:0] OP_SLTU   = 7'h0A;
    localparam logic [6:0] OP_LUI    = 7'h0B;
    localparam logic [6:0] OP_AUIPC  = 7'h0C;
    localparam logic [6:0] OP_MUL    = 7'h0D;
    localparam logic [6:0] OP_MULH   = 7'h0E;
    localparam logic [6:0] OP_MULHSU = 7'h0F;
    localparam logic [6:0] OP_MULHU  = 7'h10;
    localparam logic [6:0] OP_DIV    = 7'h11;
    localparam logic [6:0] OP_DIVU   = 7'h12;
    localparam logic [6:0] OP_REM    = 7'h13;
    localparam logic [6:0] OP_REMU   = 7'h14;
    localparam logic [6:0] OP_JAL    = 7'h15;
    localparam logic [6:0] OP_SW     = 7'h18;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr_pc_ex, r1_ex, r2_ex, store_imm_ex;
    logic        wvalid_ex, flush;
    logic [4:0]  waddr_ex;
    logic [2:0]  alusel_ex;
    logic [6:0]  aluop_ex;
    logic [5:0]  stall;
    logic        wvalid_o, stallreq_ex;
    logic [4:0]  waddr_o;
    logic [31:0] wdata_o, mem_addr_o, mem_wdata_o;
    logic [6:0]  aluop_o;

    ex_stage #(.DIV_STEPS(32)) dut (
        .clk(clk), .rst(rst), .addr_pc_ex(addr_pc_ex), .r1_ex(r1_ex), .r2_ex(r2_ex),
        .wvalid_ex(wvalid_ex), .waddr_ex(waddr_ex), .alusel_ex(alusel_ex),
        .aluop_ex(aluop_ex), .store_imm_ex(store_imm_ex), .stall(stall), .flush(flush),
        .wvalid_o(wvalid_o), .waddr_o(waddr_o), .wdata_o(wdata_o), .aluop_o(aluop_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .stallreq_ex(stallreq_ex)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] wdata;
        logic        wvalid;
        int          stall_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] sel, input logic [6:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        alusel_ex = sel;
        aluop_ex  = op;
        r1_ex     = a;
        r2_ex     = b;
        wvalid_ex = 1'b1;
        waddr_ex  = 5'd9;
    endtask

    task automatic drive_nop();
        alusel_ex = SEL_NOP;
        aluop_ex  = 7'h00;
        r1_ex     = 32'd0;
        r2_ex     = 32'd0;
        wvalid_ex = 1'b0;
        waddr_ex  = 5'd0;
    endtask

    // Reference for the M extension, written with native operators.
    function automatic logic [31:0] model_md(input logic [6:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        int              ia, ib;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        ia = a;
        ib = b;
        case (op)
            OP_MUL:    begin p = ua * ub; return p[31:0];  end
            OP_MULH:   begin p = sa * sb; return p[63:32]; end
            OP_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
            OP_MULHU:  begin p = ua * ub; return p[63:32]; end
            OP_DIV: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                else return ia / ib;
            end
            OP_REM: begin
                if (b == 32'd0) return a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                else return ia % ib;
            end
            OP_DIVU: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                else return a / b;
            end
            OP_REMU: begin
                if (b == 32'd0) return a;
                else return a % b;
            end
            default: return 32'd0;
        endcase
    endfunction

    function automatic int div_lat(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 1;
        else if ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        else return 33;
    endfunction

    // Drive one instruction, push its expectation, wait for the result, compare.
    task automatic run_op(input string tag, input logic [2:0] sel, input logic [6:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_w, input logic exp_v, input int exp_stall);
        exp_t e;
        int   cyc;
        int   bub;
        drive(sel, op, a, b);
        e = '{tag, exp_w, exp_v, exp_stall};
        sb_q.push_back(e);
        cyc = 0;
        bub = 0;
        @(negedge clk);
        while (stallreq_ex === 1'b1 && cyc < 100) begin
            cyc++;
            if (wvalid_o !== 1'b0) bub++;
            @(negedge clk);
        end
        e = sb_q.pop_front();
        check_val({e.tag, ".wdata"}, wdata_o, e.wdata);
        check_val({e.tag, ".wvalid"}, 32'(wvalid_o), 32'(e.wvalid));
        check_val({e.tag, ".stall_cycles"}, cyc, e.stall_cyc);
        check_val({e.tag, ".bubble"}, bub, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] a, b;
        logic [6:0]  op;
        rst = 1'b1;
        flush = 1'b0;
        stall = 6'd0;
        addr_pc_ex = 32'd0;
        store_imm_ex = 32'd0;
        drive_nop();
        #12;
        check_val("rst.wdata", wdata_o, 32'd0);
        check_val("rst.wvalid", 32'(wvalid_o), 32'd0);
        check_val("rst.stallreq", 32'(stallreq_ex), 32'd0);
        check_val("rst.mem_addr", mem_addr_o, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        addr_pc_ex = 32'h0000_0100;

        // Single-cycle operations
        run_op("add_ovf", SEL_ARITH, OP_ADD, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b1, 0);
        run_op("sub", SEL_ARITH, OP_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b1, 0);
        run_op("slt", SEL_ARITH, OP_SLT, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1, 1'b1, 0);
        run_op("sltu", SEL_ARITH, OP_SLTU, 32'h8000_0000, 32'h7FFF_FFFF, 32'd0, 1'b1, 0);
        run_op("lui", SEL_ARITH, OP_LUI, 32'h1234_5678, 32'hABCD_E000, 32'hABCD_E000, 1'b1, 0);
        run_op("auipc", SEL_ARITH, OP_AUIPC, 32'd0, 32'h0000_1000, 32'h0000_1100, 1'b1, 0);
        run_op("and", SEL_LOGIC, OP_AND, 32'hF0F0_FF00, 32'h0FF0_F0F0, 32'h00F0_F000, 1'b1, 0);
        run_op("or", SEL_LOGIC, OP_OR, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1'b1, 0);
        run_op("xor", SEL_LOGIC, OP_XOR, 32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00, 1'b1, 0);
        run_op("sll", SEL_SHIFT, OP_SLL, 32'h0000_0003, 32'h0000_0024, 32'h0000_0030, 1'b1, 0);
        run_op("srl", SEL_SHIFT, OP_SRL, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b1, 0);
        run_op("sra", SEL_SHIFT, OP_SRA, 32'h8000_0000, 32'h0000_003F, 32'hFFFF_FFFF, 1'b1, 0);
        run_op("jal", SEL_JUMP, OP_JAL, 32'd0, 32'd0, 32'h0000_0104, 1'b1, 0);
        run_op("nop", SEL_NOP, 7'h00, 32'h1111_1111, 32'h2222_2222, 32'd0, 1'b0, 0);

        // Multiplies
        run_op("mulh_m1", SEL_MULDIV, OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0);
        run_op("mulhu_m1", SEL_MULDIV, OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 0);
        run_op("mul_m1", SEL_MULDIV, OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 0);
        run_op("mulhsu", SEL_MULDIV, OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               model_md(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 1'b1, 0);
        for (int i = 0; i < 4; i++) begin
            a  = $urandom;
            b  = $urandom;
            op = OP_MUL + 7'(i);
            run_op("mul_rand", SEL_MULDIV, op, a, b, model_md(op, a, b), 1'b1, 0);
        end

        // Load/store address and data
        drive(SEL_LDST, OP_SW, 32'h0000_1000, 32'hDEAD_BEEF);
        store_imm_ex = 32'hFFFF_FFFC;
        #1;
        check_val("st.mem_addr", mem_addr_o, 32'h0000_0FFC);
        check_val("st.mem_wdata", mem_wdata_o, 32'hDEAD_BEEF);
        check_val("st.aluop", 32'(aluop_o), 32'(OP_SW));
        store_imm_ex = 32'd0;
        @(posedge clk);
        #1;

        // Divides: directed and special cases
        run_op("div_neg", SEL_MULDIV, OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b1, 33);
        run_op("rem_neg", SEL_MULDIV, OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b1, 33);
        run_op("divu_zero", SEL_MULDIV, OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 1);
        run_op("remu_zero", SEL_MULDIV, OP_REMU, 32'd5, 32'd0, 32'd5, 1'b1, 1);
        run_op("div_ovf", SEL_MULDIV, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1);
        run_op("rem_ovf", SEL_MULDIV, OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1, 1);
        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            b = $urandom;
            if (i == 1) b = b >> 28;
            if (i == 2) a = a >> 20;
            op = OP_DIV + 7'(i % 4);
            run_op("div_rand", SEL_MULDIV, op, a, b, model_md(op, a, b), 1'b1, div_lat(op, a, b));
        end

        // Flush at step 10 of a divide
        drive(SEL_MULDIV, OP_DIV, 32'd100, 32'd7);
        repeat (11) @(posedge clk);
        #1;
        check_val("flush.pre_stall", 32'(stallreq_ex), 32'd1);
        flush = 1'b1;
        #1;
        check_val("flush.stallreq", 32'(stallreq_ex), 32'd0);
        check_val("flush.wvalid", 32'(wvalid_o), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        run_op("add_after_flush", SEL_ARITH, OP_ADD, 32'd3, 32'd4, 32'd7, 1'b1, 0);
        run_op("div_after_flush", SEL_MULDIV, OP_DIV, 32'd100, 32'd7, 32'd14, 1'b1, 33);

        // Result held in DONE while MEM is stalled
        drive(SEL_MULDIV, OP_DIVU, 32'd1000, 32'd3);
        repeat (33) @(posedge clk);
        @(negedge clk);
        check_val("hold.done_wdata", wdata_o, 32'd333);
        check_val("hold.done_stallreq", 32'(stallreq_ex), 32'd0);
        stall = 6'b010000;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            check_val("hold.wdata", wdata_o, 32'd333);
            check_val("hold.stallreq", 32'(stallreq_ex), 32'd0);
        end
        stall = 6'd0;
        @(posedge clk);
        #1;
        check_val("hold.released", 32'(stallreq_ex), 32'd1);
        drive_nop();
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a divide
        drive(SEL_MULDIV, OP_DIV, 32'd50, 32'd5);
        repeat (5) @(posedge clk);
        #2;
        check_val("rstmid.busy", 32'(stallreq_ex), 32'd1);
        rst = 1'b1;
        #1;
        check_val("rstmid.stallreq", 32'(stallreq_ex), 32'd0);
        drive_nop();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_val("rstmid.after", 32'(stallreq_ex), 32'd0);
        run_op("div_after_rst", SEL_MULDIV, OP_DIV, 32'd50, 32'd5, 32'd10, 1'b1, 33);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
